// File: rtl/bcd_operand_entry.sv
// Operand-entry FSM: turns PS/2 make codes into two BCD operands and a one-cycle load pulse.
// Optional build macro KEYPAD_DIGITS_EN also accepts numeric-keypad digit codes.
module bcd_operand_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down_onepulse,
    input  logic [8:0] last_change,
    output logic [3:0] augend_BCD,
    output logic [3:0] addend_BCD,
    output logic       load,
    output logic [1:0] entry_state
);

    typedef enum logic [1:0] {
        StAug   = 2'd0,
        StAdd   = 2'd1,
        StReady = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       augend_q, augend_d;
    logic [3:0]       addend_q, addend_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_digit, is_enter, is_bksp, is_esc, key_known;
    logic [3:0] digit_val;

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (last_change)
            9'h045: digit_val = 4'd0;
            9'h016: digit_val = 4'd1;
            9'h01E: digit_val = 4'd2;
            9'h026: digit_val = 4'd3;
            9'h025: digit_val = 4'd4;
            9'h02E: digit_val = 4'd5;
            9'h036: digit_val = 4'd6;
            9'h03D: digit_val = 4'd7;
            9'h03E: digit_val = 4'd8;
            9'h046: digit_val = 4'd9;
`ifdef KEYPAD_DIGITS_EN
            9'h070: digit_val = 4'd0;
            9'h069: digit_val = 4'd1;
            9'h072: digit_val = 4'd2;
            9'h07A: digit_val = 4'd3;
            9'h06B: digit_val = 4'd4;
            9'h073: digit_val = 4'd5;
            9'h074: digit_val = 4'd6;
            9'h06C: digit_val = 4'd7;
            9'h075: digit_val = 4'd8;
            9'h07D: digit_val = 4'd9;
`endif
            default: is_digit = 1'b0;
        endcase
        is_enter  = (last_change == 9'h05A) || (last_change == 9'h15A);
        is_bksp   = (last_change == 9'h066);
        is_esc    = (last_change == 9'h076);
        key_known = key_down_onepulse && (is_digit || is_enter || is_bksp || is_esc);
    end

    always_comb begin
        state_d  = state_q;
        augend_d = augend_q;
        addend_d = addend_q;
        load_d   = 1'b0;
        cnt_d    = '0;
        if (key_known) begin
            // Any recognised key restarts the idle window, even if the state ignores it.
            if (is_esc) begin
                augend_d = 4'd0;
                addend_d = 4'd0;
                state_d  = StAug;
            end else begin
                case (state_q)
                    StAug: begin
                        if (is_digit) begin
                            augend_d = digit_val;
                            state_d  = StAdd;
                        end
                    end
                    StAdd: begin
                        if (is_digit) begin
                            addend_d = digit_val;
                            state_d  = StReady;
                        end else if (is_bksp) begin
                            augend_d = 4'd0;
                            state_d  = StAug;
                        end
                    end
                    StReady: begin
                        if (is_digit) begin
                            addend_d = digit_val;
                        end else if (is_enter) begin
                            load_d  = 1'b1;
                            state_d = StDone;
                        end else if (is_bksp) begin
                            addend_d = 4'd0;
                            state_d  = StAdd;
                        end
                    end
                    StDone: begin
                        if (is_digit) begin
                            augend_d = digit_val;
                            addend_d = 4'd0;
                            state_d  = StAdd;
                        end else if (is_enter) begin
                            load_d = 1'b1;
                        end
                    end
                    default: state_d = StAug;
                endcase
            end
        end else if (state_q == StAdd || state_q == StReady) begin
            if (cnt_q == CntMax) begin
                augend_d = 4'd0;
                addend_d = 4'd0;
                state_d  = StAug;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StAug;
            augend_q <= 4'd0;
            addend_q <= 4'd0;
            load_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            augend_q <= augend_d;
            addend_q <= addend_d;
            load_q   <= load_d;
            cnt_q    <= cnt_d;
        end
    end

    assign augend_BCD  = augend_q;
    assign addend_BCD  = addend_q;
    assign load        = load_q;
    assign entry_state = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with a short idle timeout (16 cycles).
// Keypad expectations follow KEYPAD_DIGITS_EN when the bench is built with it.
module tb_bcd_operand_entry;

    logic       clk;
    logic       rst;
    logic       key_down_onepulse;
    logic [8:0] last_change;
    logic [3:0] augend_BCD;
    logic [3:0] addend_BCD;
    logic       load;
    logic [1:0] entry_state;

    int checks;
    int failures;

    bcd_operand_entry #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .key_down_onepulse(key_down_onepulse),
        .last_change      (last_change),
        .augend_BCD       (augend_BCD),
        .addend_BCD       (addend_BCD),
        .load             (load),
        .entry_state      (entry_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one code; returns at the negedge right after the edge that consumed it.
    task automatic press(input logic [8:0] code);
        @(negedge clk);
        key_down_onepulse = 1'b1;
        last_change       = code;
        @(negedge clk);
        key_down_onepulse = 1'b0;
        last_change       = 9'h000;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst               = 1'b1;
        key_down_onepulse = 1'b1;
        last_change       = 9'h045;
        @(negedge clk);
        rst               = 1'b0;
        key_down_onepulse = 1'b0;
        last_change       = 9'h000;
        checks++;
        if (entry_state !== 2'd0 || augend_BCD !== 4'd0 || addend_BCD !== 4'd0 || load !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%0d aug=%0d add=%0d load=%b, want 0 0 0 0",
                     entry_state, augend_BCD, addend_BCD, load);
        end
    endtask

    task automatic test_entry;
        press(9'h026);
        checks++;
        if (entry_state !== 2'd1 || augend_BCD !== 4'd3) begin
            failures++;
            $display("FAIL entry_aug: state=%0d aug=%0d, want 1 3", entry_state, augend_BCD);
        end
        press(9'h02E);
        checks++;
        if (entry_state !== 2'd2 || addend_BCD !== 4'd5 || load !== 1'b0) begin
            failures++;
            $display("FAIL entry_add: state=%0d add=%0d load=%b, want 2 5 0",
                     entry_state, addend_BCD, load);
        end
        press(9'h05A);
        checks++;
        if (entry_state !== 2'd3 || load !== 1'b1 || augend_BCD !== 4'd3 || addend_BCD !== 4'd5) begin
            failures++;
            $display("FAIL entry_load: state=%0d load=%b aug=%0d add=%0d, want 3 1 3 5",
                     entry_state, load, augend_BCD, addend_BCD);
        end
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || entry_state !== 2'd3) begin
            failures++;
            $display("FAIL entry_pulse: load=%b state=%0d, want 0 3", load, entry_state);
        end
        // S_DONE must never time out.
        repeat (20) @(negedge clk);
        checks++;
        if (entry_state !== 2'd3 || augend_BCD !== 4'd3 || addend_BCD !== 4'd5) begin
            failures++;
            $display("FAIL done_hold: state=%0d aug=%0d add=%0d, want 3 3 5",
                     entry_state, augend_BCD, addend_BCD);
        end
        press(9'h05A);
        checks++;
        if (load !== 1'b1 || entry_state !== 2'd3) begin
            failures++;
            $display("FAIL done_reload: load=%b state=%0d, want 1 3", load, entry_state);
        end
        press(9'h066);
        checks++;
        if (load !== 1'b0 || entry_state !== 2'd3 || addend_BCD !== 4'd5) begin
            failures++;
            $display("FAIL done_bksp: load=%b state=%0d add=%0d, want 0 3 5",
                     load, entry_state, addend_BCD);
        end
    endtask

    task automatic test_edits;
        press(9'h076);
        press(9'h016);
        press(9'h01E);
        press(9'h066);
        checks++;
        if (entry_state !== 2'd1 || addend_BCD !== 4'd0 || augend_BCD !== 4'd1) begin
            failures++;
            $display("FAIL edit_bksp: state=%0d aug=%0d add=%0d, want 1 1 0",
                     entry_state, augend_BCD, addend_BCD);
        end
        press(9'h046);
        press(9'h15A);
        checks++;
        if (entry_state !== 2'd3 || load !== 1'b1 || augend_BCD !== 4'd1 || addend_BCD !== 4'd9) begin
            failures++;
            $display("FAIL edit_load: state=%0d load=%b aug=%0d add=%0d, want 3 1 1 9",
                     entry_state, load, augend_BCD, addend_BCD);
        end
        press(9'h036);
        checks++;
        if (entry_state !== 2'd1 || augend_BCD !== 4'd6 || addend_BCD !== 4'd0 || load !== 1'b0) begin
            failures++;
            $display("FAIL edit_newprob: state=%0d aug=%0d add=%0d load=%b, want 1 6 0 0",
                     entry_state, augend_BCD, addend_BCD, load);
        end
        press(9'h066);
        checks++;
        if (entry_state !== 2'd0 || augend_BCD !== 4'd0) begin
            failures++;
            $display("FAIL edit_bksp_add: state=%0d aug=%0d, want 0 0", entry_state, augend_BCD);
        end
        press(9'h03D);
        press(9'h03E);
        press(9'h045);
        checks++;
        if (entry_state !== 2'd2 || augend_BCD !== 4'd7 || addend_BCD !== 4'd0) begin
            failures++;
            $display("FAIL edit_overwrite: state=%0d aug=%0d add=%0d, want 2 7 0",
                     entry_state, augend_BCD, addend_BCD);
        end
    endtask

    task automatic test_ignore_abort;
        press(9'h076);
        press(9'h05A);
        checks++;
        if (entry_state !== 2'd0 || load !== 1'b0) begin
            failures++;
            $display("FAIL ign_enter: state=%0d load=%b, want 0 0", entry_state, load);
        end
        press(9'h025);
        press(9'h01C);
        checks++;
        if (entry_state !== 2'd1 || augend_BCD !== 4'd4 || addend_BCD !== 4'd0) begin
            failures++;
            $display("FAIL ign_unknown: state=%0d aug=%0d add=%0d, want 1 4 0",
                     entry_state, augend_BCD, addend_BCD);
        end
        press(9'h145);
        checks++;
        if (entry_state !== 2'd1 || addend_BCD !== 4'd0) begin
            failures++;
            $display("FAIL ign_ext_digit: state=%0d add=%0d, want 1 0", entry_state, addend_BCD);
        end
        press(9'h05A);
        checks++;
        if (entry_state !== 2'd1 || load !== 1'b0) begin
            failures++;
            $display("FAIL ign_enter_add: state=%0d load=%b, want 1 0", entry_state, load);
        end
        press(9'h03E);
        press(9'h076);
        checks++;
        if (entry_state !== 2'd0 || augend_BCD !== 4'd0 || addend_BCD !== 4'd0 || load !== 1'b0) begin
            failures++;
            $display("FAIL esc_ready: state=%0d aug=%0d add=%0d load=%b, want 0 0 0 0",
                     entry_state, augend_BCD, addend_BCD, load);
        end
    endtask

    task automatic test_timeout;
        press(9'h025);
        repeat (15) @(negedge clk);
        checks++;
        if (entry_state !== 2'd1 || augend_BCD !== 4'd4) begin
            failures++;
            $display("FAIL to_before: state=%0d aug=%0d, want 1 4", entry_state, augend_BCD);
        end
        @(negedge clk);
        checks++;
        if (entry_state !== 2'd0 || augend_BCD !== 4'd0) begin
            failures++;
            $display("FAIL to_expire: state=%0d aug=%0d, want 0 0", entry_state, augend_BCD);
        end
        // Digit strobe consumed on the expiry edge wins over the abort.
        press(9'h025);
        repeat (14) @(negedge clk);
        press(9'h046);
        checks++;
        if (entry_state !== 2'd2 || augend_BCD !== 4'd4 || addend_BCD !== 4'd9) begin
            failures++;
            $display("FAIL to_race: state=%0d aug=%0d add=%0d, want 2 4 9",
                     entry_state, augend_BCD, addend_BCD);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (entry_state !== 2'd2) begin
            failures++;
            $display("FAIL to_cleared: state=%0d, want 2", entry_state);
        end
        // Unrecognised key must not restart the idle window.
        press(9'h076);
        press(9'h025);
        repeat (9) @(negedge clk);
        press(9'h01C);
        repeat (4) @(negedge clk);
        checks++;
        if (entry_state !== 2'd1) begin
            failures++;
            $display("FAIL to_unk_before: state=%0d, want 1", entry_state);
        end
        @(negedge clk);
        checks++;
        if (entry_state !== 2'd0) begin
            failures++;
            $display("FAIL to_unk_expire: state=%0d, want 0", entry_state);
        end
    endtask

    task automatic test_keypad;
        logic       load_seen;
        logic [1:0] exp_state;
        logic [3:0] exp_aug;
        logic [3:0] exp_add;
`ifdef KEYPAD_DIGITS_EN
        exp_state = 2'd3;
        exp_aug   = 4'd3;
        exp_add   = 4'd1;
`else
        exp_state = 2'd0;
        exp_aug   = 4'd0;
        exp_add   = 4'd0;
`endif
        press(9'h076);
        press(9'h07A);
        press(9'h069);
        press(9'h05A);
        load_seen = load;
        checks++;
        if (entry_state !== exp_state || augend_BCD !== exp_aug || addend_BCD !== exp_add
            || load_seen !== exp_state[0]) begin
            failures++;
            $display("FAIL keypad: state=%0d aug=%0d add=%0d load=%b, want %0d %0d %0d %b",
                     entry_state, augend_BCD, addend_BCD, load_seen,
                     exp_state, exp_aug, exp_add, exp_state[0]);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        key_down_onepulse = 1'b0;
        last_change       = 9'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_entry();
        test_edits();
        test_ignore_abort();
        test_timeout();
        test_keypad();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
